// File: rtl/wb_reg_file.sv
// Writeback stage: selects load vs. ALU data, commits it to the register file,
// and serves two combinational read ports with same-cycle write bypass.
module wb_reg_file #(
    parameter int unsigned NREG      = 32,
    parameter bit          ZERO_REG  = 1'b1,
    parameter logic [31:0] COUNT_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_reg_write,
    input  logic        wb_mem_to_reg,
    input  logic [31:0] wb_mem_data,
    input  logic [31:0] wb_alu_result,
    input  logic [4:0]  wb_dst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] wb_data,
    output logic [31:0] wb_count,
    output logic [4:0]  last_dst,
    output logic [31:0] last_data
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] wb_count_q, wb_count_d;
    logic [AW-1:0] last_dst_q, last_dst_d;
    logic [DW-1:0] last_data_q, last_data_d;
    logic          commit_c;

    always_comb wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;

    // A write commits unless disabled, aimed at a hardwired $0, or out of range.
    always_comb begin
        commit_c = wb_reg_write;
        if (ZERO_REG && (wb_dst == '0)) commit_c = 1'b0;
        if (32'(wb_dst) >= NREG) commit_c = 1'b0;
    end

    always_comb begin
        rs_data = '0;
        if (ZERO_REG && (rs_addr == '0)) rs_data = '0;
        else if (commit_c && (rs_addr == wb_dst)) rs_data = wb_data;
        else if (32'(rs_addr) < NREG) rs_data = regs_q[rs_addr];
    end

    always_comb begin
        rt_data = '0;
        if (ZERO_REG && (rt_addr == '0)) rt_data = '0;
        else if (commit_c && (rt_addr == wb_dst)) rt_data = wb_data;
        else if (32'(rt_addr) < NREG) rt_data = regs_q[rt_addr];
    end

    always_comb begin
        regs_d      = regs_q;
        wb_count_d  = wb_count_q;
        last_dst_d  = last_dst_q;
        last_data_d = last_data_q;
        if (commit_c) begin
            regs_d[wb_dst] = wb_data;
            wb_count_d     = wb_count_q + 32'd1;
            last_dst_d     = wb_dst;
            last_data_d    = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
            wb_count_q  <= COUNT_RST;
            last_dst_q  <= '0;
            last_data_q <= '0;
        end else begin
            regs_q      <= regs_d;
            wb_count_q  <= wb_count_d;
            last_dst_q  <= last_dst_d;
            last_data_q <= last_data_d;
        end
    end

    assign wb_count  = wb_count_q;
    assign last_dst  = last_dst_q;
    assign last_data = last_data_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Randomized and directed bench for wb_reg_file against an array-based register model.
module tb_wb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [31:0] wb_mem_data, wb_alu_result;
    logic [4:0]  wb_dst, rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, wb_count, last_data;
    logic [4:0]  last_dst;
    logic [31:0] w_rs, w_rt, w_wbd, w_count, w_ldata;
    logic [4:0]  w_ldst;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic [4:0]  m_ldst;
    logic [31:0] m_ldata;

    always #5 clk = ~clk;

    wb_reg_file dut (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result), .wb_dst(wb_dst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .wb_count(wb_count), .last_dst(last_dst), .last_data(last_data)
    );

    // Second instance whose counter starts one short of wrapping.
    wb_reg_file #(.COUNT_RST(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result), .wb_dst(wb_dst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(w_rs), .rt_data(w_rt),
        .wb_data(w_wbd), .wb_count(w_count), .last_dst(w_ldst), .last_data(w_ldata)
    );

    function automatic logic [31:0] exp_wbd();
        return wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    endfunction

    function automatic logic exp_commit();
        return wb_reg_write && (wb_dst != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (exp_commit() && a == wb_dst) return exp_wbd();
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
        m_ldst  = 5'd0;
        m_ldata = 32'd0;
    endtask

    // Update the model for the edge that is about to consume the current inputs.
    task automatic model_edge();
        if (exp_commit()) begin
            m_regs[wb_dst] = exp_wbd();
            m_count = m_count + 32'd1;
            m_ldst  = wb_dst;
            m_ldata = exp_wbd();
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] dst,
                         input logic [4:0] rsa, input logic [4:0] rta);
        wb_reg_write  = we;
        wb_mem_to_reg = m2r;
        wb_mem_data   = mem;
        wb_alu_result = alu;
        wb_dst        = dst;
        rs_addr       = rsa;
        rt_addr       = rta;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd31);
        model_reset();
        #12;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            errors++; $display("FAIL reset_read rs=%h rt=%h expected 0", rs_data, rt_data);
        end
        checks++;
        if (wb_count !== 32'd0 || last_dst !== 5'd0 || last_data !== 32'd0) begin
            errors++; $display("FAIL reset_state count=%h ldst=%0d ldata=%h expected 0", wb_count, last_dst, last_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_wb();
        drive(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd8, 5'd1, 5'd2);
        tick();
        checks++;
        if (wb_count !== m_count || last_dst !== 5'd8 || last_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_wb count=%h ldst=%0d ldata=%h expected %h 8 deadbeef", wb_count, last_dst, last_data, m_count);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd8);
        #3;
        checks++;
        if (rt_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_readback rt=%h expected deadbeef", rt_data);
        end
        tick();
    endtask

    task automatic test_load_bypass();
        drive(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_0BAD, 5'd3, 5'd3, 5'd3);
        #3;
        checks++;
        if (rs_data !== 32'hCAFE_F00D || rt_data !== 32'hCAFE_F00D || wb_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL load_bypass rs=%h rt=%h wbd=%h expected cafef00d", rs_data, rt_data, wb_data);
        end
        tick();
        checks++;
        if (last_data !== 32'hCAFE_F00D || wb_count !== m_count) begin
            errors++; $display("FAIL load_commit ldata=%h count=%h expected cafef00d %h", last_data, wb_count, m_count);
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] cnt_before;
        cnt_before = wb_count;
        drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #3;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            errors++; $display("FAIL zero_pre rs=%h rt=%h expected 0", rs_data, rt_data);
        end
        tick();
        checks++;
        if (rs_data !== 32'd0 || wb_count !== cnt_before || wb_count !== m_count) begin
            errors++; $display("FAIL zero_post rs=%h count=%h expected 0 %h", rs_data, wb_count, m_count);
        end
    endtask

    task automatic test_disabled();
        drive(1'b1, 1'b0, 32'd0, 32'h0000_0077, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'h0000_0055, 5'd9, 5'd9, 5'd9);
        #3;
        checks++;
        if (rs_data !== 32'h77 || rt_data !== 32'h77 || wb_data !== 32'h55) begin
            errors++; $display("FAIL disabled_pre rs=%h rt=%h wbd=%h expected 77 77 55", rs_data, rt_data, wb_data);
        end
        wb_mem_to_reg = 1'b1;
        tick();
        checks++;
        if (rs_data !== 32'h77 || wb_count !== m_count || last_data !== 32'h77) begin
            errors++; $display("FAIL disabled_post rs=%h count=%h ldata=%h expected 77 %h 77", rs_data, wb_count, last_data, m_count);
        end
    endtask

    task automatic test_random();
        int bad_comb = 0;
        int bad_seq = 0;
        for (int n = 0; n < 300; n++) begin
            logic [4:0] dst;
            dst = 5'($urandom_range(0, 31));
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, dst,
                  ($urandom_range(0, 3) == 0) ? dst : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? dst : 5'($urandom));
            #3;
            checks++;
            if (rs_data !== exp_read(rs_addr) || rt_data !== exp_read(rt_addr) || wb_data !== exp_wbd()) begin
                errors++; bad_comb++;
                if (bad_comb < 5)
                    $display("FAIL rand_read n=%0d rs=%h/%h rt=%h/%h wbd=%h/%h (got/expected)", n,
                             rs_data, exp_read(rs_addr), rt_data, exp_read(rt_addr), wb_data, exp_wbd());
            end
            tick();
            checks++;
            if (wb_count !== m_count || last_dst !== m_ldst || last_data !== m_ldata) begin
                errors++; bad_seq++;
                if (bad_seq < 5)
                    $display("FAIL rand_state n=%0d count=%h/%h ldst=%0d/%0d ldata=%h/%h (got/expected)", n,
                             wb_count, m_count, last_dst, m_ldst, last_data, m_ldata);
            end
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(a), 5'(31 - a));
            #1;
            checks++;
            if (rs_data !== exp_read(5'(a)) || rt_data !== exp_read(5'(31 - a))) begin
                errors++; $display("FAIL sweep a=%0d rs=%h/%h rt=%h/%h (got/expected)", a,
                                   rs_data, exp_read(5'(a)), rt_data, exp_read(5'(31 - a)));
            end
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 1'b0, 32'd0, 32'h0000_1234, 5'd5, 5'd5, 5'd5);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
        #1;
        checks++;
        if (rs_data !== 32'h1234) begin
            errors++; $display("FAIL midrun_pre rs=%h expected 1234", rs_data);
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rs_data !== 32'd0 || wb_count !== 32'd0 || last_data !== 32'd0 || last_dst !== 5'd0) begin
            errors++; $display("FAIL midrun_reset rs=%h count=%h ldata=%h ldst=%0d expected 0", rs_data, wb_count, last_data, last_dst);
        end
        // A write presented while reset is held must be discarded.
        drive(1'b1, 1'b0, 32'd0, 32'h0000_ABCD, 5'd6, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd6, 5'd5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0 || wb_count !== 32'd0) begin
            errors++; $display("FAIL reset_write_drop rs=%h rt=%h count=%h expected 0", rs_data, rt_data, wb_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_wrap();
        checks++;
        if (w_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_start count=%h expected ffffffff", w_count);
        end
        drive(1'b1, 1'b1, 32'h0F0F_0F0F, 32'd0, 5'd17, 5'd17, 5'd0);
        #3;
        checks++;
        if (w_rs !== 32'h0F0F_0F0F || w_rt !== 32'd0 || w_wbd !== 32'h0F0F_0F0F) begin
            errors++; $display("FAIL wrap_bypass rs=%h rt=%h wbd=%h expected 0f0f0f0f 0 0f0f0f0f", w_rs, w_rt, w_wbd);
        end
        tick();
        checks++;
        if (w_count !== 32'd0 || w_ldst !== 5'd17 || w_ldata !== 32'h0F0F_0F0F || wb_count !== m_count) begin
            errors++; $display("FAIL wrap_edge count=%h ldst=%0d ldata=%h main=%h expected 0 17 0f0f0f0f %h",
                               w_count, w_ldst, w_ldata, wb_count, m_count);
        end
        drive(1'b1, 1'b0, 32'd0, 32'h2, 5'd18, 5'd17, 5'd18);
        tick();
        checks++;
        if (w_count !== 32'd1 || w_rs !== 32'h0F0F_0F0F) begin
            errors++; $display("FAIL wrap_after count=%h rs=%h expected 1 0f0f0f0f", w_count, w_rs);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_alu_wb();
        test_load_bypass();
        test_zero_reg();
        test_disabled();
        test_random();
        test_reset_midrun();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule
